nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

- Multi-cycle WIDTH-bit adder built on one shared `fulladder_4bit` slice.
- Latches two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Steps one 4-bit nibble per clock through the slice, LSB first, carrying between nibbles in a register.
- Presents the full sum and carry-out through an output valid/ready handshake.
- Sits directly upstream of the 4-bit adder: it is the sequencer that feeds the slice and assembles its results.

## Interface
- `WIDTH`, 16: operand/sum width; must be a multiple of 4 and ≥ 8.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry into nibble 0.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `sum` output WIDTH: registered result.
- `cout` output 1: carry out of the top nibble.
- `ovf` output 1: signed overflow; present only with `NSA_OVERFLOW_EN`.

## Operation
- NIB = WIDTH/4. Nibble index counter `idx` is clog2(NIB) bits wide.
- States:
  - IDLE: `in_ready`=1.
    - `in_valid` -> latch `a`, `b`, `cin` into op regs.
    - Same edge: `idx`←0, carry reg←`cin`, go to RUN.
  - RUN:
    - Slice inputs are `a_reg[4*idx+:4]`, `b_reg[4*idx+:4]` and the carry reg.
    - Each edge: `sum[4*idx+:4]`←slice sum, carry reg←slice cout, `idx`←`idx`+1.
    - At `idx`==NIB-1: `cout`←slice cout and go to DONE.
  - DONE: `out_valid`=1; `sum`/`cout` held stable.
    - `out_ready` -> IDLE.
- `in_ready` = (state==IDLE) and `out_valid` = (state==DONE); both decode combinationally from the state register.
- `in_valid` outside IDLE is ignored. Operands are not captured and are not queued.
- Unsigned wrap: `sum` = (a+b+cin) mod 2^WIDTH; `cout` = bit WIDTH of the true sum.
- `sum` bits not yet written in RUN hold stale values; they are valid only in DONE.
- Reset values: state IDLE, `sum`=0, `cout`=0, `ovf`=0, carry reg 0, `idx`=0. Hence `in_ready`=1 and `out_valid`=0.
- Reset asserted mid-RUN or mid-DONE aborts the operation immediately. No `out_valid` is produced for it.

## Timing
- Accept edge T0 (`in_valid`&&`in_ready`).
- RUN occupies edges T1..T_NIB; `out_valid` is high from the cycle after edge T_NIB.
- Latency is NIB+1 edges from accept to `out_valid`: 5 edges for WIDTH=16.
- `out_valid` and `sum` hold for as many cycles as `out_ready` stays low.
- Next accept is possible one cycle after the `out_ready` handshake edge. Minimum initiation interval is NIB+2 cycles.
- Single slice, so the combinational path is one 4-bit ripple per cycle, independent of WIDTH.

## Configuration
- `NSA_OVERFLOW_EN` defined:
  - `ovf` port exists.
  - Registered on the last RUN edge as (a_msb == b_msb) && (sum_msb != a_msb), using the top-nibble slice sum.
  - Reset value 0; held through DONE.
- Not defined: `ovf` port and its register are absent. Other behaviour is identical.

## Structure
- Shared package `nsa_pkg` holds:
  - `NIB_W`=4.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and decodes to IDLE.
  - Function `nib_count(WIDTH)`.
- One sub-module: the existing `fulladder_4bit`, instantiated exactly once. No other arithmetic in the block.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0:
  - `out_valid` rises 5 edges after accept.
  - `sum`=0x5555, `cout`=0.
- a=0xFFFF, b=0x0001, cin=0:
  - `sum`=0x0000, `cout`=1 (carry crosses all nibbles).
  - With macro, `ovf`=0.
- a=0x7FFF, b=0x0000, cin=1:
  - `sum`=0x8000, `cout`=0.
  - With macro, `ovf`=1.
- a=0x00F0, b=0x0010, cin=0, `out_ready` held low 6 cycles:
  - `sum`=0x0100 and `out_valid` stay stable throughout.
  - `in_ready`=0 and a pulsed `in_valid` is ignored.
  - After `out_ready`, `in_ready`=1 next cycle.
- Accept a=0xAAAA, b=0x5555; assert `rst` on edge T2:
  - `in_ready`=1, `out_valid`=0, `sum`=0 immediately.
  - No result emerges.
  - A following a=0x0001, b=0x0001 yields 0x0002.

Source files
------------

// File: rtl/nsa_pkg.sv
// nsa_pkg - shared definitions for nibble_serial_adder.
//   NIB_W       : slice width in bits (one nibble)
//   nsa_state_t : sequencer state encoding; 2'd3 is illegal and recovers to IDLE
//   nib_count() : number of nibbles in a WIDTH-bit operand
package nsa_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } nsa_state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/fulladder_4bit.sv
// fulladder_4bit - 4-bit ripple adder slice.
//   a, b  : nibble operands
//   cin   : carry in
//   sum   : nibble sum
//   cout  : carry out
module fulladder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder - WIDTH-bit adder that reuses one fulladder_4bit slice,
// processing one nibble per clock, LSB first.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   ovf                  : signed overflow, only when NSA_OVERFLOW_EN is defined
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one nibble per edge through the slice, idx selects nibble
//   DONE  | result held, out_valid=1 until out_ready
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB    = nib_count(WIDTH);
  localparam int IDX_W  = $clog2(NIB);
  localparam int BASE_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  nsa_state_t state, state_nxt;

  logic [WIDTH-1:0]  a_reg, b_reg;
  logic              carry;
  logic [IDX_W-1:0]  idx;
  logic [BASE_W-1:0] base;
  logic              load, step, is_last;

  logic [NIB_W-1:0]  sl_a, sl_b, sl_sum;
  logic              sl_cout;

  // bit offset of the current nibble: idx*4
  assign base    = {idx, 2'b00};
  assign is_last = (idx == IDX_LAST);
  assign sl_a    = a_reg[base +: NIB_W];
  assign sl_b    = b_reg[base +: NIB_W];

  fulladder_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (is_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (load) begin
      a_reg <= a;
      b_reg <= b;
      carry <= cin;
      idx   <= '0;
    end else if (step) begin
      sum[base +: NIB_W] <= sl_sum;
      carry              <= sl_cout;
      idx                <= idx + 1'b1;
      if (is_last) cout <= sl_cout;
    end
  end

`ifdef NSA_OVERFLOW_EN
  // signed overflow: operands agree in sign but the top-nibble result does not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (step && is_last) begin
      ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sl_sum[NIB_W-1] != a_reg[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NSA_OVERFLOW_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive operands for one accept edge; returns #1 after that edge
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // count edges from accept (inclusive) until out_valid, bounded
  task automatic wait_done(input string tag);
    int edges;
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, 5);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, in_ready, 1);
    check({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tc, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    accept(ta, tb, tc);
    check({tag, "_busy"}, in_ready, 0);
    wait_done(tag);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
`ifdef NSA_OVERFLOW_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unexpected x expectation in %s", tag);
`endif
    release_result(tag);
  endtask

  initial begin
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("carry",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin_ov", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    run_op("back2b", 16'h0009, 16'h0008, 1'b1, 16'h0012, 1'b0, 1'b0);

    // backpressure: result must hold while out_ready is low
    accept(16'h00F0, 16'h0010, 1'b0);
    wait_done("stall");
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      check($sformatf("stall_sum_%0d", i), sum, 16'h0100);
      check($sformatf("stall_valid_%0d", i), out_valid, 1);
      check($sformatf("stall_in_ready_%0d", i), in_ready, 0);
    end
    check("stall_cout", cout, 0);
    release_result("stall");
    // the pulse seen in DONE must not have been queued
    repeat (7) @(posedge clk);
    #1;
    check("stall_no_queue_valid", out_valid, 0);
    check("stall_no_queue_ready", in_ready, 1);
    check("stall_no_queue_sum", sum, 16'h0100);

    // reset mid-RUN
    accept(16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      check("abort_no_result", seen, 0);
    end
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
